mvu_pe_acc: RTL and testbench

- Per-PE accumulator stage directly downstream of the PE adder tree.
- Consumes one registered SIMD-sum per cycle and accumulates SF consecutive partial sums (one synapse fold) into a wider accumulator.
- Emits one finished dot-product per fold through a single-entry valid/ready output register feeding the PE output/threshold stage.

---
 rtl/mvu_pe_acc_if.sv | 39 +++
 rtl/mvu_pe_acc.sv | 98 +++++++++
 tb/tb_mvu_pe_acc.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mvu_pe_acc_if.sv
// mvu_pe_acc_if: handshake bundle around the per-PE accumulator.
//   in_data/in_v/in_rdy    : partial-sum stream from the adder tree
//   out_data/out_v/out_rdy : finished dot-product stream to the output stage
//   out_sat                : fold saturated (only with MVU_PE_ACC_SAT_EN)
// Handshake: a transfer happens on a rising edge where valid && ready;
// a producer holds its data stable while valid is high and ready is low.
// Modports: slave = accumulator side, master = adder-tree/consumer side.
interface mvu_pe_acc_if #(
  parameter int TDstI = 4,
  parameter int TAccO = 16
);
  logic [TDstI-1:0] in_data;
  logic             in_v;
  logic             in_rdy;
  logic [TAccO-1:0] out_data;
  logic             out_v;
  logic             out_rdy;
`ifdef MVU_PE_ACC_SAT_EN
  logic             out_sat;

  modport slave (
    input  in_data, in_v, out_rdy,
    output in_rdy, out_data, out_v, out_sat
  );
  modport master (
    output in_data, in_v, out_rdy,
    input  in_rdy, out_data, out_v, out_sat
  );
`else
  modport slave (
    input  in_data, in_v, out_rdy,
    output in_rdy, out_data, out_v
  );
  modport master (
    output in_data, in_v, out_rdy,
    input  in_rdy, out_data, out_v
  );
`endif
endinterface

// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: per-PE accumulator behind the adder tree. Sums SF consecutive
// signed partial sums (one synapse fold) into a TAccO-wide accumulator and
// hands each finished sum to a single-entry valid/ready output register.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset (clears a partially built fold)
//   bus    : mvu_pe_acc_if.slave (in_data/in_v/in_rdy, out_data/out_v/out_rdy,
//            plus out_sat when saturation is built in)
// Build option: define MVU_PE_ACC_SAT_EN to saturate every add to the signed
// TAccO range and report it on out_sat; otherwise adds wrap modulo 2^TAccO.
module mvu_pe_acc #(
  parameter int TDstI = 4,
  parameter int TAccO = 16,
  parameter int SF    = 4
) (
  input  logic        clock,
  input  logic        resetn,
  mvu_pe_acc_if.slave bus
);

  localparam int              CW   = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0]   LAST = CW'(SF - 1);

  logic signed [TAccO-1:0] acc;
  logic signed [TAccO-1:0] in_ext;
  logic signed [TAccO-1:0] sum;
  logic        [CW-1:0]    cnt;
  logic        [TAccO-1:0] out_data_q;
  logic                    out_v_q;
  logic                    last;
  logic                    fire;

  assign in_ext = TAccO'($signed(bus.in_data));
  assign last   = (cnt == LAST);

  // Only the fold-completing beat needs output space; non-last beats never
  // touch the output register. Depends on out_rdy, never on in_v.
  assign bus.in_rdy = !(last && out_v_q && !bus.out_rdy);
  assign fire       = bus.in_v && bus.in_rdy;

`ifdef MVU_PE_ACC_SAT_EN
  logic signed [TAccO:0] wide;
  logic                  ovf;
  logic                  sat_fold;
  logic                  out_sat_q;

  // One guard bit: overflow iff the two top bits of the widened sum differ.
  assign wide = {acc[TAccO-1], acc} + {in_ext[TAccO-1], in_ext};
  assign ovf  = wide[TAccO] ^ wide[TAccO-1];
  assign sum  = !ovf          ? wide[TAccO-1:0] :
                wide[TAccO]   ? {1'b1, {(TAccO-1){1'b0}}} :
                                {1'b0, {(TAccO-1){1'b1}}};
  assign bus.out_sat = out_sat_q;
`else
  assign sum = acc + in_ext;
`endif

  assign bus.out_data = out_data_q;
  assign bus.out_v    = out_v_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      out_v_q    <= 1'b0;
`ifdef MVU_PE_ACC_SAT_EN
      sat_fold   <= 1'b0;
      out_sat_q  <= 1'b0;
`endif
    end else begin
      // Drain first; a last beat in the same cycle overrides it below so a
      // new result replaces the old one without a bubble.
      if (out_v_q && bus.out_rdy) begin
        out_v_q <= 1'b0;
      end
      if (fire) begin
        if (last) begin
          out_data_q <= sum;
          out_v_q    <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
`ifdef MVU_PE_ACC_SAT_EN
          out_sat_q  <= sat_fold | ovf;
          sat_fold   <= 1'b0;
`endif
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
`ifdef MVU_PE_ACC_SAT_EN
          sat_fold <= sat_fold | ovf;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb_mvu_pe_acc: directed bench for mvu_pe_acc.
//   dut_a : TDstI=8, TAccO=16, SF=4 (folds, bubbles, backpressure, reset)
//   dut_b : TDstI=8, TAccO=8,  SF=4 (overflow: wrap or saturate)
//   dut_c : TDstI=4, TAccO=16, SF=1 (every beat is a last beat)
module tb_mvu_pe_acc;

  logic clock;
  logic resetn;

  mvu_pe_acc_if #(.TDstI(8), .TAccO(16)) a_if ();
  mvu_pe_acc_if #(.TDstI(8), .TAccO(8))  b_if ();
  mvu_pe_acc_if #(.TDstI(4), .TAccO(16)) c_if ();

  mvu_pe_acc #(.TDstI(8), .TAccO(16), .SF(4)) dut_a (.clock(clock), .resetn(resetn), .bus(a_if));
  mvu_pe_acc #(.TDstI(8), .TAccO(8),  .SF(4)) dut_b (.clock(clock), .resetn(resetn), .bus(b_if));
  mvu_pe_acc #(.TDstI(4), .TAccO(16), .SF(1)) dut_c (.clock(clock), .resetn(resetn), .bus(c_if));

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every result leaving dut_a is matched against the expected queue.
  always @(negedge clock) begin
    if (resetn && a_if.out_v && a_if.out_rdy) begin
      if (exp_q.size() == 0) check("a_spurious_out", 32'(a_if.out_v), 32'd0);
      else                   check("a_out_data", 32'(a_if.out_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one beat on dut_a, return how many cycles it waited for in_rdy.
  task automatic send_a(input logic [7:0] v, output int waits);
    logic rdy;
    waits = 0;
    rdy = 1'b0;
    a_if.in_v    = 1'b1;
    a_if.in_data = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      rdy = a_if.in_rdy;
      @(posedge clock);
      if (rdy) break;
      waits++;
    end
    if (!rdy) check("a_send_timeout", 32'(rdy), 32'd1);
    #1;
    a_if.in_v = 1'b0;
  endtask

  // One full fold of four equal beats on dut_b, then check its result.
  task automatic fold_b(input logic [7:0] v, input logic [7:0] exp_d, input logic exp_s);
    for (int i = 0; i < 4; i++) begin
      b_if.in_v    = 1'b1;
      b_if.in_data = v;
      @(negedge clock);
      check("b_in_rdy", 32'(b_if.in_rdy), 32'd1);
      @(posedge clock);
      #1;
    end
    b_if.in_v = 1'b0;
    @(negedge clock);
    check("b_out_v", 32'(b_if.out_v), 32'd1);
    check("b_out_data", 32'(b_if.out_data), 32'(exp_d));
`ifdef MVU_PE_ACC_SAT_EN
    check("b_out_sat", 32'(b_if.out_sat), 32'(exp_s));
`else
    if (exp_s) begin end
`endif
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  int w;
  logic [7:0]  av[8];
  logic [3:0]  cv[3];
  logic [15:0] ce[3];

  initial begin
    resetn = 1'b0;
    a_if.in_v = 1'b0; a_if.in_data = '0; a_if.out_rdy = 1'b1;
    b_if.in_v = 1'b0; b_if.in_data = '0; b_if.out_rdy = 1'b1;
    c_if.in_v = 1'b0; c_if.in_data = '0; c_if.out_rdy = 1'b1;
    idle(2);
    @(negedge clock);
    check("rst_out_v",    32'(a_if.out_v),    32'd0);
    check("rst_out_data", 32'(a_if.out_data), 32'd0);
    check("rst_in_rdy",   32'(a_if.in_rdy),   32'd1);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Basic fold: 3 - 1 + 10 + 5 = 17, no stalls, out_v for one cycle.
    exp_q.push_back(16'd17);
    av[0] = 8'd3; av[1] = 8'hFF; av[2] = 8'd10; av[3] = 8'd5;
    for (int i = 0; i < 4; i++) begin
      send_a(av[i], w);
      check("basic_wait", 32'(w), 32'd0);
    end
    @(negedge clock);
    check("basic_out_v_rise", 32'(a_if.out_v), 32'd1);
    @(negedge clock);
    check("basic_out_v_fall", 32'(a_if.out_v), 32'd0);
    idle(1);

    // Bubbles after beats 2 and 5 do not disturb the fold position.
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd8);
    for (int i = 0; i < 8; i++) begin
      send_a(8'd2, w);
      if (i == 1 || i == 4) idle(1);
    end
    idle(2);

    // Backpressure: completing beat waits, result held, then drain+load.
    a_if.out_rdy = 1'b0;
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd4);
    for (int i = 1; i <= 4; i++) send_a(8'(i), w);
    for (int i = 0; i < 3; i++) begin
      send_a(8'd1, w);
      check("bp_nonlast_wait", 32'(w), 32'd0);
    end
    a_if.in_v = 1'b1; a_if.in_data = 8'd1;
    @(negedge clock);
    check("bp_in_rdy_low",  32'(a_if.in_rdy),   32'd0);
    check("bp_hold_data",   32'(a_if.out_data), 32'd10);
    @(posedge clock); #1;
    @(negedge clock);
    check("bp_in_rdy_low2", 32'(a_if.in_rdy),   32'd0);
    check("bp_hold_data2",  32'(a_if.out_data), 32'd10);
    check("bp_hold_v",      32'(a_if.out_v),    32'd1);
    @(posedge clock); #1;
    a_if.out_rdy = 1'b1;
    @(negedge clock);
    check("bp_in_rdy_release", 32'(a_if.in_rdy), 32'd1);
    @(posedge clock); #1;
    a_if.in_v = 1'b0;
    @(negedge clock);
    check("drain_load_v", 32'(a_if.out_v), 32'd1);
    idle(2);

    // Sustained streaming: no waits, results 10 and 26.
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd26);
    for (int i = 1; i <= 8; i++) begin
      send_a(8'(i), w);
      check("stream_wait", 32'(w), 32'd0);
    end
    idle(2);

    // Reset mid-fold discards the two beats already taken.
    send_a(8'd100, w);
    send_a(8'd100, w);
    resetn = 1'b0;
    @(negedge clock);
    check("rst_mid_v", 32'(a_if.out_v), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("rst_after_v",    32'(a_if.out_v),    32'd0);
    check("rst_after_data", 32'(a_if.out_data), 32'd0);
    exp_q.push_back(16'd4);
    for (int i = 0; i < 4; i++) send_a(8'd1, w);
    idle(2);

    // Overflow on an 8-bit accumulator.
`ifdef MVU_PE_ACC_SAT_EN
    fold_b(8'd127, 8'h7F, 1'b1);
    fold_b(8'h80,  8'h80, 1'b1);
    fold_b(8'd1,   8'd4,  1'b0);
`else
    fold_b(8'd127, 8'hFC, 1'b0);
    fold_b(8'h80,  8'h00, 1'b0);
    fold_b(8'd1,   8'd4,  1'b0);
`endif

    // SF=1: every beat is a result, sign-extended, back-to-back.
    cv[0] = 4'hD; ce[0] = 16'hFFFD;
    cv[1] = 4'h7; ce[1] = 16'h0007;
    cv[2] = 4'h8; ce[2] = 16'hFFF8;
    c_if.in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_if.in_data = cv[i];
      @(posedge clock); #1;
      @(negedge clock);
      check("c_out_v",    32'(c_if.out_v),    32'd1);
      check("c_out_data", 32'(c_if.out_data), 32'(ce[i]));
      check("c_in_rdy",   32'(c_if.in_rdy),   32'd1);
    end
    c_if.in_v = 1'b0;
    idle(2);

    check("a_pending_results", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
